// File: rtl/mod_sched_if.sv
// mod_sched_if: DMA channel handshakes plus engine control pins around the scheduler
interface mod_sched_if;
    logic        ch0_req;
    logic [23:0] ch0_dc;
    logic        ch0_gnt;
    logic        ch0_done;
    logic        ch0_err;
    logic        ch1_req;
    logic [23:0] ch1_dc;
    logic        ch1_gnt;
    logic        ch1_done;
    logic        ch1_err;
    logic [7:0]  m_cap;
    logic        m_endn;
    logic        m_reset;
    logic        m_enable;
    logic [23:0] dc;
    logic        busy;
    logic [1:0]  err_code;
    logic [15:0] jobs_done;
    modport master (
        output ch0_req, ch0_dc, ch1_req, ch1_dc, m_cap, m_endn,
        input  ch0_gnt, ch0_done, ch0_err, ch1_gnt, ch1_done, ch1_err,
        input  m_reset, m_enable, dc, busy, err_code, jobs_done
    );
    modport slave (
        input  ch0_req, ch0_dc, ch1_req, ch1_dc, m_cap, m_endn,
        output ch0_gnt, ch0_done, ch0_err, ch1_gnt, ch1_done, ch1_err,
        output m_reset, m_enable, dc, busy, err_code, jobs_done
    );
endinterface

// File: rtl/mod_sched.sv
// mod_sched: round-robin two-channel scheduler sequencing jobs on the shared compression engine
module mod_sched #(
    parameter int unsigned     RST_CYC = 4,
    parameter int unsigned     TO_W    = 20,
    parameter logic [TO_W-1:0] TIMEOUT = 20'hF_FFFF
) (
    input logic        wb_clk_i,
    input logic        wb_rst_n,
    mod_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RST, RUN, DONE, ERR} state_t;
    state_t          state;
    logic            rr, sel, first, busy, m_reset, m_enable;
    logic [1:0]      gnt, done, err, err_code;
    logic [3:0]      rst_cnt;
    logic [TO_W-1:0] wd;
    logic [23:0]     dc;
    logic [15:0]     jobs_done;
    logic            win, one_hot, cap_ok;
    logic [23:0]     win_dc;
    logic [6:0]      op;
    // rr holds the last served channel; on contention the other one wins
    assign win     = (bus.ch0_req && bus.ch1_req) ? ~rr : bus.ch1_req;
    assign win_dc  = win ? bus.ch1_dc : bus.ch0_dc;
    assign op      = win_dc[6:0];
    assign one_hot = (op != 7'd0) && ((op & (op - 7'd1)) == 7'd0);
    assign cap_ok  = |({1'b0, op} & bus.m_cap);
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            rr        <= 1'b1;
            sel       <= 1'b0;
            first     <= 1'b0;
            busy      <= 1'b0;
            m_reset   <= 1'b1;
            m_enable  <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            err_code  <= '0;
            rst_cnt   <= '0;
            wd        <= '0;
            dc        <= '0;
            jobs_done <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: if (bus.ch0_req || bus.ch1_req) begin
                    rr       <= win;
                    sel      <= win;
                    gnt[win] <= 1'b1;
                    dc       <= win_dc;
                    busy     <= 1'b1;
                    rst_cnt  <= '0;
                    if (one_hot && cap_ok) state <= RST;
                    else begin
                        state    <= ERR;
                        err[win] <= 1'b1;
                        err_code <= one_hot ? 2'd2 : 2'd1;
                    end
                end
                RST: if (rst_cnt == 4'(RST_CYC - 1)) begin
                    state    <= RUN;
                    m_reset  <= 1'b0;
                    m_enable <= 1'b1;
                    wd       <= '0;
                    first    <= 1'b1;
                end else rst_cnt <= rst_cnt + 4'd1;
                RUN: begin
                    first <= 1'b0;
                    wd    <= wd + TO_W'(1);
                    // completion takes priority over a same-cycle watchdog expiry
                    if (!first && !bus.m_endn) begin
                        state     <= DONE;
                        m_reset   <= 1'b1;
                        m_enable  <= 1'b0;
                        done[sel] <= 1'b1;
                        jobs_done <= jobs_done + 16'd1;
                        err_code  <= 2'd0;
                    end else if (TIMEOUT != '0 && wd == TIMEOUT - TO_W'(1)) begin
                        state    <= ERR;
                        m_reset  <= 1'b1;
                        m_enable <= 1'b0;
                        err[sel] <= 1'b1;
                        err_code <= 2'd3;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    dc    <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.ch0_gnt   = gnt[0];
    assign bus.ch1_gnt   = gnt[1];
    assign bus.ch0_done  = done[0];
    assign bus.ch1_done  = done[1];
    assign bus.ch0_err   = err[0];
    assign bus.ch1_err   = err[1];
    assign bus.m_reset   = m_reset;
    assign bus.m_enable  = m_enable;
    assign bus.dc        = dc;
    assign bus.busy      = busy;
    assign bus.err_code  = err_code;
    assign bus.jobs_done = jobs_done;
endmodule

// File: tb/tb_mod_sched.sv
// tb_mod_sched: directed and random jobs against a job-level model of the scheduler
module tb_mod_sched;
    localparam int RC = 4;
    localparam int TO = 100;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int last = 1;
    int jobs_m = 0;
    mod_sched_if bus();
    mod_sched #(.RST_CYC(RC), .TO_W(20), .TIMEOUT(20'd100)) dut (
        .wb_clk_i(clk),
        .wb_rst_n(rst_n),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [23:0] rnd_dc();
        logic [23:0] v;
        v = 24'($urandom);
        if ($urandom_range(0, 3) != 0) v[6:0] = 7'(1 << $urandom_range(0, 6));
        return v;
    endfunction
    function automatic logic [31:0] pulses();
        return 32'({bus.ch1_done, bus.ch0_done, bus.ch1_err, bus.ch0_err});
    endfunction
    // Called at a negedge with the requests already driven; runs one job to its end.
    task automatic serve(input logic [7:0] cap, input int pa, input int pb, input bit keep);
        int w, code, en, first_en, exp_n;
        bit fin;
        logic [23:0] wdc;
        logic [6:0] op;
        w = (bus.ch0_req && bus.ch1_req) ? 1 - last : (bus.ch1_req ? 1 : 0);
        last = w;
        wdc = w ? bus.ch1_dc : bus.ch0_dc;
        op = wdc[6:0];
        code = ($countones(op) != 1) ? 1 : (((op & cap[6:0]) == 7'd0) ? 2 : 0);
        exp_n = 0;
        if (code == 0) begin
            for (int k = 2; k <= TO; k++) if (exp_n == 0 && (k == pa || k == pb)) exp_n = k;
            if (exp_n == 0) code = 3;
        end
        bus.m_cap = cap;
        en = 0;
        first_en = 0;
        fin = 1'b0;
        for (int n = 1; n <= 400 && !fin; n++) begin
            @(negedge clk);
            bus.m_endn = 1'b1;
            check("gnt", 32'({bus.ch1_gnt, bus.ch0_gnt}), w ? 32'd2 : 32'd1);
            check("dc", 32'(bus.dc), 32'(wdc));
            if (bus.m_enable) begin
                en++;
                if (first_en == 0) first_en = n;
                if (en == pa || en == pb) bus.m_endn = 1'b0;
            end
            fin = bus.ch0_done | bus.ch1_done | bus.ch0_err | bus.ch1_err;
        end
        if (code == 0) jobs_m = (jobs_m + 1) % 65536;
        check("finished", 32'(fin), 32'd1);
        check("pulse", pulses(), code == 0 ? 32'(1 << (2 + w)) : 32'(1 << w));
        check("err_code", 32'(bus.err_code), 32'(code));
        check("jobs_done", 32'(bus.jobs_done), 32'(jobs_m));
        check("end_enable", 32'(bus.m_enable), 32'd0);
        check("end_reset", 32'(bus.m_reset), 32'd1);
        check("end_busy", 32'(bus.busy), 32'd1);
        check("en_cycles", 32'(en), code == 0 ? 32'(exp_n) : (code == 3 ? 32'(TO) : 32'd0));
        check("en_rise", 32'(first_en), (code == 1 || code == 2) ? 32'd0 : 32'(RC + 1));
        if (!keep) begin
            if (w == 1) bus.ch1_req = 1'b0;
            else bus.ch0_req = 1'b0;
        end
        @(negedge clk);
        check("idle_gnt", 32'({bus.ch1_gnt, bus.ch0_gnt}), 32'd0);
        check("idle_dc", 32'(bus.dc), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_pulse", pulses(), 32'd0);
    endtask
    initial begin
        bit hit;
        bus.ch0_req = 1'b0;
        bus.ch1_req = 1'b0;
        bus.ch0_dc = '0;
        bus.ch1_dc = '0;
        bus.m_cap = 8'h60;
        bus.m_endn = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_m_reset", 32'(bus.m_reset), 32'd1);
        check("rst_m_enable", 32'(bus.m_enable), 32'd0);
        check("rst_dc", 32'(bus.dc), 32'd0);
        check("rst_gnt", 32'({bus.ch1_gnt, bus.ch0_gnt}), 32'd0);
        check("rst_pulse", pulses(), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err_code", 32'(bus.err_code), 32'd0);
        check("rst_jobs", 32'(bus.jobs_done), 32'd0);
        rst_n = 1'b1;
        // single job
        bus.ch0_dc = 24'h000020;
        bus.ch0_req = 1'b1;
        serve(8'h60, 10, 0, 1'b0);
        // contention with both channels held
        bus.ch0_dc = 24'h000040;
        bus.ch1_dc = 24'h000040;
        bus.ch0_req = 1'b1;
        bus.ch1_req = 1'b1;
        repeat (4) serve(8'h60, 3, 0, 1'b1);
        bus.ch0_req = 1'b0;
        bus.ch1_req = 1'b0;
        // rejects
        bus.ch1_dc = 24'h000060;
        bus.ch1_req = 1'b1;
        serve(8'h60, 5, 0, 1'b0);
        bus.ch1_dc = 24'h000001;
        bus.ch1_req = 1'b1;
        serve(8'h60, 5, 0, 1'b0);
        // watchdog, then recovery
        bus.ch0_dc = 24'h000020;
        bus.ch0_req = 1'b1;
        serve(8'h60, 0, 0, 1'b0);
        bus.ch0_req = 1'b1;
        serve(8'h60, 7, 0, 1'b0);
        // boundaries: first RUN cycle, earliest completion, timeout cycle, one past it
        bus.ch0_req = 1'b1;
        serve(8'h60, 1, 0, 1'b0);
        bus.ch0_req = 1'b1;
        serve(8'h60, 1, 2, 1'b0);
        bus.ch1_dc = 24'hABCD20;
        bus.ch1_req = 1'b1;
        serve(8'h60, TO, 0, 1'b0);
        bus.ch1_req = 1'b1;
        serve(8'h60, TO + 1, 0, 1'b0);
        // m_endn activity while idle
        for (int i = 0; i < 6; i++) begin
            bus.m_endn = i[0];
            @(negedge clk);
            check("idle_endn_busy", 32'(bus.busy), 32'd0);
            check("idle_endn_en", 32'(bus.m_enable), 32'd0);
            check("idle_endn_jobs", 32'(bus.jobs_done), 32'(jobs_m));
        end
        bus.m_endn = 1'b1;
        // random traffic
        for (int j = 0; j < 40; j++) begin
            if (!bus.ch0_req && $urandom_range(0, 1) == 1) begin
                bus.ch0_dc = rnd_dc();
                bus.ch0_req = 1'b1;
            end
            if (!bus.ch1_req && $urandom_range(0, 1) == 1) begin
                bus.ch1_dc = rnd_dc();
                bus.ch1_req = 1'b1;
            end
            if (!bus.ch0_req && !bus.ch1_req) begin
                bus.ch0_dc = rnd_dc();
                bus.ch0_req = 1'b1;
            end
            serve(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h7F,
                  int'($urandom_range(1, 110)), int'($urandom_range(0, 110)),
                  $urandom_range(0, 3) == 0);
        end
        bus.ch0_req = 1'b0;
        bus.ch1_req = 1'b0;
        @(negedge clk);
        // asynchronous reset in the middle of RUN
        bus.ch0_dc = 24'h000020;
        bus.m_cap = 8'h60;
        bus.ch0_req = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk);
            hit = bus.m_enable;
        end
        check("mid_run_reached", 32'(hit), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_enable", 32'(bus.m_enable), 32'd0);
        check("arst_reset", 32'(bus.m_reset), 32'd1);
        check("arst_gnt", 32'({bus.ch1_gnt, bus.ch0_gnt}), 32'd0);
        check("arst_pulse", pulses(), 32'd0);
        check("arst_jobs", 32'(bus.jobs_done), 32'd0);
        @(negedge clk);
        check("arst_hold_pulse", pulses(), 32'd0);
        rst_n = 1'b1;
        last = 1;
        jobs_m = 0;
        bus.ch1_dc = 24'h000040;
        bus.ch1_req = 1'b1;
        serve(8'h60, 4, 0, 1'b0);
        serve(8'h60, 4, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
